draw_game_board: RTL and testbench

- Minesweeper board renderer in the VGA pixel path, between vga_timing and the later overlay stages.
- On entering PLAY it reads the game settings registers from main_fsm over a Wishbone master and caches them.
- It then continuously mirrors the board field states over a second Wishbone master.
- It overlays the board grid on the incoming VGA stream with one clock of latency.

---
 rtl/game_pkg.sv | 40 ++++
 rtl/vga_pkg.sv | 9 +
 rtl/vga_if.sv | 13 +
 rtl/wishbone_if.sv | 14 +
 rtl/board_pixel_locator.sv | 81 ++++++++
 rtl/draw_game_board.sv | 165 ++++++++++++++++
 tb/tb_draw_game_board.sv | 232 +++++++++++++++++++++++
 7 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: main FSM codes, settings register map, level presets
// and the packed layout of one board field.
package game_pkg;

  localparam logic [2:0] MENU  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] PLAY  = 3'd2;
  localparam logic [2:0] WIN   = 3'd3;
  localparam logic [2:0] LOSE  = 3'd4;

  localparam int ROW_COLUMN_NUMBER_REG_NUM = 0;
  localparam int MINE_NUM_REG_NUM          = 1;
  localparam int TIMER_SECONDS_REG_NUM     = 2;
  localparam int FIELD_SIZE_REG_NUM        = 3;
  localparam int BOARD_SIZE_REG_NUM        = 4;
  localparam int BOARD_XPOS_REG_NUM        = 5;
  localparam int BOARD_YPOS_REG_NUM        = 6;

  localparam logic [15:0] M_ROW_COLUMN_NUMBER = 16'd10;
  localparam logic [15:0] M_MINE_NUM          = 16'd15;
  localparam logic [15:0] M_TIMER_SECONDS     = 16'd300;
  localparam logic [15:0] M_FIELD_SIZE        = 16'd8;
  localparam logic [15:0] M_BOARD_SIZE        = 16'd80;
  localparam logic [15:0] M_BOARD_XPOS        = 16'd100;
  localparam logic [15:0] M_BOARD_YPOS        = 16'd50;

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    READ_SETTINGS = 2'd1,
    DRAW          = 2'd2
  } board_state_t;

  typedef struct packed {
    logic [3:0] adj;
    logic       mine;
    logic       flag;
    logic       defused;
  } field_t;

endpackage

// File: rtl/vga_pkg.sv
// 800x600 VGA timing constants shared by the pixel pipeline stages.
package vga_pkg;

  localparam int HOR_TOTAL_TIME  = 1056;
  localparam int HOR_BLANK_START = 800;
  localparam int VER_TOTAL_TIME  = 628;
  localparam int VER_BLANK_START = 600;

endpackage

// File: rtl/vga_if.sv
// One VGA pixel-stream stage: timing counters, sync/blank flags and colour.
interface vga_if;
  logic [10:0] vcount;
  logic [10:0] hcount;
  logic        vsync;
  logic        vblnk;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
  modport out (output vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
endinterface

// File: rtl/wishbone_if.sv
// Classic single-beat Wishbone bus; a transfer completes on the clock where
// cyc&stb are high and ack is high, after which the master drops stb.
interface wishbone_if;
  logic [7:0]  adr;
  logic [15:0] dat_w;
  logic [15:0] dat_r;
  logic        we;
  logic        stb;
  logic        cyc;
  logic        ack;

  modport master (output adr, dat_w, we, stb, cyc, input dat_r, ack);
  modport slave  (input adr, dat_w, we, stb, cyc, output dat_r, ack);
endinterface

// File: rtl/board_pixel_locator.sv
// Maps the current pixel to a board field and in-field offset using counters
// that restart at the board origin, so no divider is needed.
module board_pixel_locator #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [10:0]   i_hcount,
  input  logic [10:0]   i_vcount,
  input  logic [15:0]   i_xpos,
  input  logic [15:0]   i_ypos,
  input  logic [15:0]   i_field_size,
  input  logic [15:0]   i_board_size,
  output logic          o_in_board,
  output logic [DW-1:0] o_row,
  output logic [DW-1:0] o_col,
  output logic          o_grid
);
  logic [15:0] w_h, w_v, w_fs_m1;
  logic [16:0] w_xend, w_yend;
  logic        w_line_start;
  logic [15:0] r_hoff, r_hcol, r_voff, r_vrow;
  logic [15:0] w_hoff, w_hcol, w_voff_nx, w_vrow_nx, w_voff, w_vrow;

  assign w_h          = {5'd0, i_hcount};
  assign w_v          = {5'd0, i_vcount};
  assign w_fs_m1      = i_field_size - 16'd1;
  assign w_xend       = {1'b0, i_xpos} + {1'b0, i_board_size};
  assign w_yend       = {1'b0, i_ypos} + {1'b0, i_board_size};
  assign w_line_start = (w_h == i_xpos);

  // Horizontal counters step every pixel; vertical ones step once per line,
  // at the pixel where the line crosses the board's left edge.
  always_comb begin
    w_hoff    = r_hoff + 16'd1;
    w_hcol    = r_hcol;
    w_voff_nx = r_voff + 16'd1;
    w_vrow_nx = r_vrow;
    if (w_line_start) begin
      w_hoff = '0;
      w_hcol = '0;
    end else if (r_hoff == w_fs_m1) begin
      w_hoff = '0;
      w_hcol = r_hcol + 16'd1;
    end
    if (w_v == i_ypos) begin
      w_voff_nx = '0;
      w_vrow_nx = '0;
    end else if (r_voff == w_fs_m1) begin
      w_voff_nx = '0;
      w_vrow_nx = r_vrow + 16'd1;
    end
  end

  assign w_voff = w_line_start ? w_voff_nx : r_voff;
  assign w_vrow = w_line_start ? w_vrow_nx : r_vrow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hoff <= '0;
      r_hcol <= '0;
      r_voff <= '0;
      r_vrow <= '0;
    end else begin
      r_hoff <= w_hoff;
      r_hcol <= w_hcol;
      if (w_line_start) begin
        r_voff <= w_voff_nx;
        r_vrow <= w_vrow_nx;
      end
    end
  end

  assign o_in_board = (i_field_size != 16'd0) &&
                      (w_h >= i_xpos) && ({1'b0, w_h} < w_xend) &&
                      (w_v >= i_ypos) && ({1'b0, w_v} < w_yend);
  assign o_row      = w_vrow[DW-1:0];
  assign o_col      = w_hcol[DW-1:0];
  assign o_grid     = (w_hoff == 16'd0) || (w_voff == 16'd0);

endmodule

// File: rtl/draw_game_board.sv
// Minesweeper board renderer: caches the game settings, mirrors the board
// fields over Wishbone and overlays the grid on the VGA stream (1 clock).
module draw_game_board
  import game_pkg::*;
#(
  parameter int MAX_DIM          = 16,
  parameter int SETTINGS_REG_NUM = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] main_state,
  wishbone_if.master game_settings_wb,
  wishbone_if.master game_board_wb,
  vga_if.in          in,
  vga_if.out         out
);
  localparam int DW = $clog2(MAX_DIM);
  localparam int IW = $clog2(SETTINGS_REG_NUM);
  localparam int CW = $clog2(SETTINGS_REG_NUM + 1);

  board_state_t  board_state, w_next_state;
  logic [CW-1:0] settings_read_ctr;
  logic [15:0]   game_setup_cashe [SETTINGS_REG_NUM];
  field_t        game_board_mem [MAX_DIM][MAX_DIM];

  logic          r_set_gap, r_brd_gap;
  logic [DW-1:0] r_brd_row, r_brd_col;
  logic          w_set_stb, w_brd_stb, w_set_ack, w_brd_ack;
  logic [15:0]   w_rcn;
  logic [DW-1:0] w_last_idx;
  logic          w_in_board, w_grid;
  logic [DW-1:0] w_row, w_col;
  field_t        w_field;
  logic [11:0]   w_rgb;
  logic          w_unused_bits;

  always_ff @(posedge clk) begin
    if (rst) board_state <= IDLE;
    else     board_state <= w_next_state;
  end

  always_comb begin
    w_next_state = board_state;
    if (main_state != PLAY) begin
      w_next_state = IDLE;
    end else begin
      case (board_state)
        IDLE:          w_next_state = READ_SETTINGS;
        READ_SETTINGS: if (w_set_ack &&
                           settings_read_ctr == CW'(SETTINGS_REG_NUM - 1))
                         w_next_state = DRAW;
        DRAW:          w_next_state = DRAW;
        default:       w_next_state = IDLE;
      endcase
    end
  end

  // A strobe is withheld for the single clock after each ack.
  always_comb begin
    w_set_stb = (board_state == READ_SETTINGS) && !r_set_gap;
    w_brd_stb = (board_state == DRAW) && !r_brd_gap;
  end

  assign w_set_ack = w_set_stb && game_settings_wb.ack;
  assign w_brd_ack = w_brd_stb && game_board_wb.ack;

  assign game_settings_wb.cyc   = w_set_stb;
  assign game_settings_wb.stb   = w_set_stb;
  assign game_settings_wb.we    = 1'b0;
  assign game_settings_wb.dat_w = '0;
  assign game_settings_wb.adr   = 8'(settings_read_ctr);
  assign game_board_wb.cyc      = w_brd_stb;
  assign game_board_wb.stb      = w_brd_stb;
  assign game_board_wb.we       = 1'b0;
  assign game_board_wb.dat_w    = '0;
  assign game_board_wb.adr      = 8'({r_brd_row, r_brd_col});

  assign w_rcn = (game_setup_cashe[ROW_COLUMN_NUMBER_REG_NUM] > 16'(MAX_DIM)) ?
                 16'(MAX_DIM) : game_setup_cashe[ROW_COLUMN_NUMBER_REG_NUM];
  assign w_last_idx = (w_rcn == 16'd0) ? '0 : DW'(w_rcn - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      settings_read_ctr <= '0;
      r_set_gap         <= 1'b0;
      r_brd_gap         <= 1'b0;
      r_brd_row         <= '0;
      r_brd_col         <= '0;
      for (int i = 0; i < SETTINGS_REG_NUM; i++) game_setup_cashe[i] <= '0;
      for (int r = 0; r < MAX_DIM; r++)
        for (int c = 0; c < MAX_DIM; c++) game_board_mem[r][c] <= '0;
    end else begin
      r_set_gap <= w_set_ack;
      r_brd_gap <= w_brd_ack;
      if (board_state == IDLE) begin
        settings_read_ctr <= '0;
      end else if (w_set_ack) begin
        game_setup_cashe[settings_read_ctr[IW-1:0]] <= game_settings_wb.dat_r;
        settings_read_ctr <= settings_read_ctr + 1'b1;
      end
      if (board_state != DRAW) begin
        r_brd_row <= '0;
        r_brd_col <= '0;
      end else if (w_brd_ack) begin
        game_board_mem[r_brd_row][r_brd_col] <= field_t'(game_board_wb.dat_r[6:0]);
        if (r_brd_col >= w_last_idx) begin
          r_brd_col <= '0;
          r_brd_row <= (r_brd_row >= w_last_idx) ? '0 : r_brd_row + 1'b1;
        end else begin
          r_brd_col <= r_brd_col + 1'b1;
        end
      end
    end
  end

  board_pixel_locator #(.DW(DW)) u_locator (
    .clk          (clk),
    .rst          (rst),
    .i_hcount     (in.hcount),
    .i_vcount     (in.vcount),
    .i_xpos       (game_setup_cashe[BOARD_XPOS_REG_NUM]),
    .i_ypos       (game_setup_cashe[BOARD_YPOS_REG_NUM]),
    .i_field_size (game_setup_cashe[FIELD_SIZE_REG_NUM]),
    .i_board_size (game_setup_cashe[BOARD_SIZE_REG_NUM]),
    .o_in_board   (w_in_board),
    .o_row        (w_row),
    .o_col        (w_col),
    .o_grid       (w_grid)
  );

  assign w_field       = game_board_mem[w_row][w_col];
  assign w_unused_bits = ^{game_board_wb.dat_r[15:7], w_field.adj};

  always_comb begin
    w_rgb = in.rgb;
    if (in.hblnk || in.vblnk)                       w_rgb = 12'h000;
    else if (!w_in_board || board_state != DRAW)   w_rgb = in.rgb;
    else if (w_grid)                               w_rgb = 12'h444;
    else if (w_field.defused && w_field.mine)      w_rgb = 12'h000;
    else if (w_field.defused)                      w_rgb = 12'hDDD;
    else if (w_field.flag)                         w_rgb = 12'hF00;
    else                                           w_rgb = 12'hAAA;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out.hcount <= '0;
      out.vcount <= '0;
      out.hsync  <= 1'b0;
      out.vsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      out.hcount <= in.hcount;
      out.vcount <= in.vcount;
      out.hsync  <= in.hsync;
      out.vsync  <= in.vsync;
      out.hblnk  <= in.hblnk;
      out.vblnk  <= in.vblnk;
      out.rgb    <= w_rgb;
    end
  end

endmodule

// File: tb/tb_draw_game_board.sv
// Bench for draw_game_board: Wishbone slave models, randomized board contents
// and pixel stream, and a division-based reference for the rendered colour.
module tb_draw_game_board;
  import game_pkg::*;

  // Clock / reset
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] main_state;
  always #5 clk = ~clk;

  wishbone_if set_wb ();
  wishbone_if brd_wb ();
  vga_if      vin ();
  vga_if      vout ();

  draw_game_board dut (
    .clk              (clk),
    .rst              (rst),
    .main_state       (main_state),
    .game_settings_wb (set_wb),
    .game_board_wb    (brd_wb),
    .in               (vin),
    .out              (vout)
  );

  // Slave memories and responders (ack 1..4 clocks after strobe)
  logic [15:0] setup_mem [8];
  logic [15:0] board_mem [256];
  int          set_wait = 0;
  int          brd_wait = 0;
  bit          mon_en = 1'b0;
  bit          seen [256] = '{default: 1'b0};
  int          bad_adr = 0;

  always @(posedge clk) begin
    if (rst) begin
      set_wb.ack   <= 1'b0;
      set_wb.dat_r <= '0;
      set_wait     <= 0;
    end else if (set_wb.cyc && set_wb.stb && !set_wb.ack) begin
      if (set_wait == 0) begin
        set_wb.ack   <= 1'b1;
        set_wb.dat_r <= setup_mem[set_wb.adr[2:0]];
        set_wait     <= $urandom_range(0, 3);
      end else set_wait <= set_wait - 1;
    end else set_wb.ack <= 1'b0;
  end

  always @(posedge clk) begin
    if (rst) begin
      brd_wb.ack   <= 1'b0;
      brd_wb.dat_r <= '0;
      brd_wait     <= 0;
    end else if (brd_wb.cyc && brd_wb.stb && !brd_wb.ack) begin
      if (brd_wait == 0) begin
        brd_wb.ack   <= 1'b1;
        brd_wb.dat_r <= board_mem[brd_wb.adr];
        brd_wait     <= $urandom_range(0, 3);
        if (mon_en) begin
          seen[brd_wb.adr] <= 1'b1;
          if (brd_wb.adr[7:4] >= 4'd10 || brd_wb.adr[3:0] >= 4'd10) bad_adr <= bad_adr + 1;
        end
      end else brd_wait <= brd_wait - 1;
    end else brd_wb.ack <= 1'b0;
  end

  // Scoreboard
  int          n_vec = 0;
  int          n_err = 0;
  logic [37:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference colour from the board rules using plain division/modulo
  function automatic logic [11:0] model_rgb(input int h, input int v, input bit hb,
                                            input bit vb, input logic [11:0] rgb,
                                            input bit drawing, output string tag);
    int x, y, fs, bs, dx, dy;
    logic [15:0] f;
    x  = int'(setup_mem[5]);
    y  = int'(setup_mem[6]);
    fs = int'(setup_mem[3]);
    bs = int'(setup_mem[4]);
    if (hb || vb) begin tag = "blank"; return 12'h000; end
    if (!drawing || fs == 0 || h < x || h >= x + bs || v < y || v >= y + bs) begin
      tag = "pass"; return rgb;
    end
    dx = h - x;
    dy = v - y;
    if (dx % fs == 0 || dy % fs == 0) begin tag = "grid"; return 12'h444; end
    f = board_mem[(dy / fs) * 16 + dx / fs];
    if (f[0] && f[2]) begin tag = "f_mine";    return 12'h000; end
    if (f[0])         begin tag = "f_defused"; return 12'hDDD; end
    if (f[1])         begin tag = "f_flag";    return 12'hF00; end
    tag = "f_covered";
    return 12'hAAA;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic px_step(input int h, input int v, input bit hb, input bit vb, input bit drawing);
    logic [11:0] rgb = 12'($urandom);
    logic        hs  = 1'($urandom);
    logic        vs  = 1'($urandom);
    logic [37:0] e;
    string       tag;
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.hsync  = hs;
    vin.vsync  = vs;
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.rgb    = rgb;
    exp_q.push_back({11'(h), 11'(v), hs, vs, hb, vb, model_rgb(h, v, hb, vb, rgb, drawing, tag)});
    tick();
    e = exp_q.pop_front();
    check("vga_timing", {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk},
          e[37:12]);
    check(tag, vout.rgb, e[11:0]);
  endtask

  task automatic wait_state(input board_state_t s, input int limit, input string tag);
    int k = 0;
    while (dut.board_state != s && k < limit) begin tick(); k++; end
    check(tag, 32'(dut.board_state), 32'(s));
  endtask

  task automatic wait_cyc(input int limit, input string tag);
    int k = 0;
    while (!set_wb.cyc && k < limit) begin tick(); k++; end
    check(tag, {set_wb.cyc, set_wb.adr, 4'(dut.settings_read_ctr)}, {1'b1, 8'h00, 4'h0});
  endtask

  initial begin
    int k, n_seen;
    logic [15:0] presets [8];
    presets = '{M_ROW_COLUMN_NUMBER, M_MINE_NUM, M_TIMER_SECONDS, M_FIELD_SIZE,
                M_BOARD_SIZE, M_BOARD_XPOS, M_BOARD_YPOS, 16'h0000};
    rst        = 1'b1;
    main_state = PLAY;
    vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
    vin.hblnk  = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;
    for (int i = 0; i < 8; i++) setup_mem[i] = 16'(i);
    for (int i = 0; i < 256; i++) board_mem[i] = {9'd0, 7'($urandom)};
    board_mem[2*16+2] = 16'h0001;
    board_mem[9*16+8] = 16'h0002;
    board_mem[3*16+9] = 16'h0005;

    // Reset: outputs and bus idle while pixels keep arriving
    for (int i = 0; i < 10; i++) begin
      vin.hcount = 11'($urandom); vin.vcount = 11'($urandom);
      vin.hsync = 1'($urandom); vin.vsync = 1'($urandom); vin.rgb = 12'($urandom);
      tick();
      check("rst_out", {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}, 0);
      check("rst_rgb", vout.rgb, 0);
      check("rst_wb", {set_wb.cyc, set_wb.stb, brd_wb.cyc, brd_wb.stb, set_wb.adr}, 0);
    end
    rst = 1'b0;
    vin.hcount = '0; vin.vcount = '0;
    tick();
    tick();
    check("state_after_rst", 32'(dut.board_state), 32'(READ_SETTINGS));

    k = 0;
    while (dut.settings_read_ctr == 0 && k < 98) begin tick(); k++; end
    check("ctr_nonzero", 32'(dut.settings_read_ctr != 0), 1);
    wait_state(DRAW, 200, "reach_draw");
    for (int i = 0; i < 8; i++)
      check($sformatf("cache%0d", i), dut.game_setup_cashe[i], 16'(i));

    // Leave PLAY, check passthrough while not drawing, then re-read presets
    for (int i = 0; i < 8; i++) setup_mem[i] = presets[i];
    main_state = SETUP;
    tick();
    check("leave_play", {30'(dut.board_state), set_wb.cyc, brd_wb.cyc}, 0);
    px_step(112, 62, 1'b0, 1'b0, 1'b0);
    main_state = PLAY;
    wait_cyc(10, "reread_start");
    k = 0;
    while (dut.settings_read_ctr < 3 && k < 60) begin tick(); k++; end
    main_state = MENU;
    tick();
    check("drop_state", 32'(dut.board_state), 32'(IDLE));
    check("drop_bus", {set_wb.cyc, set_wb.stb}, 0);
    repeat (3) tick();
    main_state = PLAY;
    wait_cyc(10, "reread_idx0");
    wait_state(DRAW, 200, "reach_draw2");
    for (int i = 0; i < 8; i++)
      check($sformatf("preset%0d", i), dut.game_setup_cashe[i], presets[i]);

    // Let the mirror sweep the 10x10 board a few times
    mon_en = 1'b1;
    repeat (1500) tick();
    mon_en = 1'b0;
    tick();
    n_seen = 0;
    for (int i = 0; i < 256; i++) if (seen[i]) n_seen++;
    check("mirror_range", bad_adr, 0);
    check("mirror_cover", n_seen, 100);

    // Raster over the board with margins, random blanking and colours
    for (int v = int'(M_BOARD_YPOS) - 2; v < int'(M_BOARD_YPOS + M_BOARD_SIZE) + 2; v++)
      for (int h = int'(M_BOARD_XPOS) - 3; h < int'(M_BOARD_XPOS + M_BOARD_SIZE) + 3; h++)
        px_step(h, v, ($urandom_range(0, 29) == 0),
                (v == int'(M_BOARD_YPOS) - 2) || ($urandom_range(0, 59) == 0), 1'b1);

    // Zero field size means no board at all
    main_state = SETUP;
    setup_mem[3] = 16'd0;
    tick();
    main_state = PLAY;
    wait_state(DRAW, 200, "reach_draw_fs0");
    for (int i = 0; i < 6; i++)
      px_step($urandom_range(101, 179), $urandom_range(51, 129), 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
